// File: rtl/formula_loader_pkg.sv
// Shared SAT formula layout plus the token and loader-state types used by the loader.
package formula_loader_pkg;

    localparam int unsigned number_literal    = 5;
    localparam int unsigned number_clauses    = 10;
    localparam int unsigned width_litarray    = $clog2(number_literal + 1) - 1;
    localparam int unsigned width_clausearray = $clog2(number_clauses + 1) - 1;

    typedef struct packed {
        logic [width_litarray:0] num;
        logic                    val;
    } lit;

    typedef struct packed {
        logic [width_litarray:0]   len;
        lit [number_literal-1:0]   lits;
    } clause;

    typedef struct packed {
        logic [width_clausearray:0]  len;
        clause [number_clauses-1:0]  clauses;
    } formula;

    localparam clause  zero_clause  = '0;
    localparam formula zero_formula = '0;

    localparam logic [width_litarray:0]    max_lit_num = (width_litarray + 1)'(number_literal);
    localparam logic [width_clausearray:0] max_clauses = (width_clausearray + 1)'(number_clauses);

    typedef enum logic [1:0] {
        TK_LIT         = 2'd0,
        TK_END_CLAUSE  = 2'd1,
        TK_END_FORMULA = 2'd2,
        TK_RESERVED    = 2'd3
    } tok_kind_t;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } loader_state_t;

endpackage

// File: rtl/formula_loader_if.sv
// Token input and formula output handshakes of the loader.
interface formula_loader_if;
    import formula_loader_pkg::*;

    logic                    tok_valid;
    logic                    tok_ready;
    tok_kind_t               tok_kind;
    logic [width_litarray:0] tok_num;
    logic                    tok_val;
    formula                  f_out;
    logic                    f_err;
    logic                    f_valid;
    logic                    f_ready;

    modport master (
        output tok_valid, tok_kind, tok_num, tok_val, f_ready,
        input  tok_ready, f_out, f_err, f_valid
    );

    modport slave (
        input  tok_valid, tok_kind, tok_num, tok_val, f_ready,
        output tok_ready, f_out, f_err, f_valid
    );

endinterface

// File: rtl/formula_loader_clause_builder.sv
// Working clause under construction: literal slots plus current length.
module formula_loader_clause_builder
    import formula_loader_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear_i,
    input  logic  append_i,
    input  lit    lit_i,
    output clause clause_o,
    output logic  clause_full_o,
    output logic  clause_empty_o
);

    lit [number_literal-1:0]  lits_q, lits_d;
    logic [width_litarray:0]  cur_len_q, cur_len_d;

    assign clause_full_o  = (cur_len_q == max_lit_num);
    assign clause_empty_o = (cur_len_q == '0);
    assign clause_o       = '{len: cur_len_q, lits: lits_q};

    // Clear wins over append; append writes the next free slot.
    always_comb begin
        lits_d    = lits_q;
        cur_len_d = cur_len_q;
        if (clear_i) begin
            lits_d    = '0;
            cur_len_d = '0;
        end else if (append_i && !clause_full_o) begin
            for (int unsigned i = 0; i < number_literal; i++) begin
                if (cur_len_q == (width_litarray + 1)'(i)) begin
                    lits_d[i] = lit_i;
                end
            end
            cur_len_d = cur_len_q + 1'b1;
        end
    end

    // Clause state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lits_q    <= '0;
            cur_len_q <= '0;
        end else begin
            lits_q    <= lits_d;
            cur_len_q <= cur_len_d;
        end
    end

endmodule

// File: rtl/formula_loader.sv
// Token stream to formula assembler: FSM, clause commit and registered formula output.
module formula_loader
    import formula_loader_pkg::*;
(
    input logic             clk,
    input logic             rst,
    formula_loader_if.slave bus
);

    loader_state_t              state_q;
    formula                     work_q;
    logic [width_clausearray:0] f_len_q;
    formula                     f_out_q;
    logic                       f_err_q;
    logic                       f_valid_q;

    clause  cb_clause;
    logic   cb_full, cb_empty, cb_clear, cb_append;
    logic   accept, lit_bad, commit_overflow;
    formula commit_f;

    assign bus.tok_ready = !rst && (state_q != S_DONE);
    assign bus.f_out     = f_out_q;
    assign bus.f_err     = f_err_q;
    assign bus.f_valid   = f_valid_q;

    formula_loader_clause_builder u_clause_builder (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (cb_clear),
        .append_i       (cb_append),
        .lit_i          ('{num: bus.tok_num, val: bus.tok_val}),
        .clause_o       (cb_clause),
        .clause_full_o  (cb_full),
        .clause_empty_o (cb_empty)
    );

    // Token decode and clause builder control for the current cycle.
    always_comb begin
        accept          = bus.tok_valid && bus.tok_ready;
        lit_bad         = (bus.tok_num == '0) || (bus.tok_num > max_lit_num) || cb_full;
        commit_overflow = !cb_empty && (f_len_q == max_clauses);
        cb_append       = 1'b0;
        cb_clear        = 1'b0;
        if (accept && state_q == S_COLLECT) begin
            if (bus.tok_kind == TK_LIT) begin
                cb_append = !lit_bad;
                cb_clear  = lit_bad;
            end else begin
                // Commit, empty-clause drop and every error all leave the clause empty.
                cb_clear = 1'b1;
            end
        end
    end

    // Working formula with the open clause appended at slot f_len.
    always_comb begin
        commit_f = work_q;
        for (int unsigned c = 0; c < number_clauses; c++) begin
            if (f_len_q == (width_clausearray + 1)'(c)) begin
                commit_f.clauses[c] = cb_clause;
            end
        end
        commit_f.len = f_len_q + 1'b1;
    end

    // Loader FSM with registered formula outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_COLLECT;
            work_q    <= zero_formula;
            f_len_q   <= '0;
            f_out_q   <= zero_formula;
            f_err_q   <= 1'b0;
            f_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        unique case (bus.tok_kind)
                            TK_LIT: begin
                                if (lit_bad) begin
                                    work_q  <= zero_formula;
                                    f_len_q <= '0;
                                    state_q <= S_DRAIN;
                                end
                            end
                            TK_END_CLAUSE: begin
                                if (commit_overflow) begin
                                    work_q  <= zero_formula;
                                    f_len_q <= '0;
                                    state_q <= S_DRAIN;
                                end else if (!cb_empty) begin
                                    work_q  <= commit_f;
                                    f_len_q <= f_len_q + 1'b1;
                                end
                            end
                            TK_END_FORMULA: begin
                                work_q    <= zero_formula;
                                f_len_q   <= '0;
                                f_valid_q <= 1'b1;
                                state_q   <= S_DONE;
                                if (commit_overflow) begin
                                    f_out_q <= zero_formula;
                                    f_err_q <= 1'b1;
                                end else begin
                                    f_out_q <= cb_empty ? work_q : commit_f;
                                    f_err_q <= 1'b0;
                                end
                            end
                            default: begin
                                // Reserved kind: fail immediately without draining.
                                work_q    <= zero_formula;
                                f_len_q   <= '0;
                                f_out_q   <= zero_formula;
                                f_err_q   <= 1'b1;
                                f_valid_q <= 1'b1;
                                state_q   <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    if (accept && bus.tok_kind == TK_END_FORMULA) begin
                        f_out_q   <= zero_formula;
                        f_err_q   <= 1'b1;
                        f_valid_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.f_ready) begin
                        work_q    <= zero_formula;
                        f_len_q   <= '0;
                        f_valid_q <= 1'b0;
                        state_q   <= S_COLLECT;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/formula_loader.md
# formula_loader

Streaming front end of the SAT solver. Accepts a token stream (literals, clause terminators, a formula terminator) over a valid/ready handshake and assembles it into one `formula` struct. The struct uses the shared `lit`/`clause`/`formula` layout. The loader then presents the completed formula to the solver core over a second valid/ready handshake. It is the writer side of the `formula` data structure that the solver reads.

## Interface
Parameters are taken from the shared package, not overridden per instance:
- number_literal, 5, maximum literals per clause and highest legal variable number
- number_clauses, 10, maximum clauses per formula
- width_litarray / width_clausearray, derived, MSB index of literal-number/clause-length and formula-length fields

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tok_valid  in  1  token present
- tok_ready  out  1  loader accepts token this cycle
- tok_kind  in  2  tok_kind_t: TK_LIT=0, TK_END_CLAUSE=1, TK_END_FORMULA=2, 3 reserved
- tok_num  in  width_litarray+1  variable number (TK_LIT only)
- tok_val  in  1  polarity, 1 = positive literal (TK_LIT only)
- f_out  out  $bits(formula)  assembled formula
- f_err  out  1  qualifies f_out: formula was malformed, f_out is zero_formula
- f_valid  out  1  f_out/f_err valid
- f_ready  in  1  solver consumes formula

## Operation
- A token transfers when tok_valid && tok_ready; a formula transfers when f_valid && f_ready.
- States (loader_state_t): S_COLLECT, S_DRAIN, S_DONE.
- S_COLLECT, TK_LIT: write {tok_num, tok_val} into slot cur_len of the working clause; cur_len++.
- S_COLLECT, TK_END_CLAUSE: if cur_len>0, write the working clause into clauses[f_len] with len=cur_len; f_len++; clear the working clause. If cur_len==0, ignore the token (empty clause dropped).
- S_COLLECT, TK_END_FORMULA: implicitly commit an open non-empty clause (same rules and checks as TK_END_CLAUSE), latch f_out, f_err=0, go to S_DONE.
- Error conditions, checked in S_COLLECT at token accept:
  - TK_LIT with tok_num==0 or tok_num>number_literal
  - TK_LIT with cur_len==number_literal
  - clause commit with f_len==number_clauses
  - tok_kind==3
- On error: discard the working state and go to S_DRAIN. If the erroring token is TK_END_FORMULA (overflow on implicit commit) or tok_kind==3, do not drain: latch zero_formula, f_err=1, go to S_DONE directly.
- S_DRAIN: accept and discard tokens until TK_END_FORMULA, then latch zero_formula, f_err=1, go to S_DONE.
- S_DONE: hold f_out/f_err. On the formula transfer, reset the working formula to zero_formula and the counters to 0, then go to S_COLLECT.
- Literal order is preserved: first literal in lits[0], first clause in clauses[0]. Unused slots stay zero. Duplicates and tautologies are stored unmodified.

## Timing
- Reset (rst high at an edge): state S_COLLECT; f_out=zero_formula, f_err=0, f_valid=0; cur_len=0, f_len=0. tok_ready is forced 0 while rst is high.
- tok_ready = !rst && state!=S_DONE (combinational from state).
- f_valid = (state==S_DONE), registered. It rises the cycle after the TK_END_FORMULA transfer.
- Formula transfer at edge N: tok_ready is high in cycle N+1, so one token bubble occurs per formula. Throughput is one token per cycle otherwise.
- f_out and f_err are stable while f_valid && !f_ready.
- rst mid-formula or during S_DONE drops everything; a pending f_valid deasserts the next cycle.
- cur_len ranges 0..number_literal and f_len ranges 0..number_clauses; neither wraps, because overflow is caught as an error first.

## Structure
- Add to the shared package: tok_kind_t enum, loader_state_t enum. Reuse lit, clause, formula, zero_clause, zero_formula.
- One natural sub-module: clause_builder. It owns the working clause and cur_len, exposes clause_full and clause_empty, and supports a clear and an append.
- Top level holds the FSM, f_len, clause commit, and the output register.

## Test plan
- Stream LIT(1,1) LIT(2,0) END_CLAUSE LIT(3,1) END_FORMULA -> f_valid one cycle later. f_out: len=2; clauses[0]={len 2, lits[0]={1,1}, lits[1]={2,0}}; clauses[1]={len 1, lits[0]={3,1}}; f_err=0.
- Same stream with f_ready low 5 cycles -> f_out constant, tok_ready=0 throughout. Transfer on cycle 6, tok_ready=1 next cycle.
- END_CLAUSE END_CLAUSE LIT(4,0) END_FORMULA -> empty clauses dropped, len=1, clauses[0]={len 1,{4,0}}.
- Six LITs then END_CLAUSE LIT(1,1) END_FORMULA -> remaining tokens drained, f_err=1, f_out=zero_formula. Next formula loads cleanly.
- Eleven single-literal clauses; separately LIT(0,1) and LIT(6,0) -> f_err=1 in each case.
- Three LITs then rst for 1 cycle, then LIT(5,1) END_FORMULA -> len=1, clauses[0]={len 1,{5,1}}, no residue from before reset.
